// File: rtl/mem_pkg.sv
// Shared constants and types for the memory initiator.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  // Memory rw pin encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Controller states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_DRAIN = 3'd2;
  localparam logic [2:0] ST_WR       = 3'd3;
  localparam logic [2:0] ST_WIPE     = 3'd4;

  // One read slot in flight: word present, and whether it closes the burst
  typedef struct packed {
    logic vld;
    logic last;
  } trk_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side request/response bundle of the memory initiator.
interface mem_ctrl_if #(
  parameter int addr_width = 8,
  parameter int data_width = 16,
  parameter int len_width  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rw;
  logic [addr_width-1:0] req_addr;
  logic [len_width-1:0]  req_len;
  logic [data_width-1:0] req_wdata;
  logic                  wipe;
  logic                  busy;
  logic                  rsp_valid;
  logic [data_width-1:0] rsp_data;
  logic                  rsp_last;

  modport master (
    output req_valid, req_rw, req_addr, req_len, req_wdata, wipe,
    input  req_ready, busy, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, req_wdata, wipe,
    output req_ready, busy, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/mem_rd_track.sv
// Latency pipe tracking which memory cycles carry read words.
// Stage 1 lines up with the request on the memory pins, stage STAGES
// with the cycle in which mem_dout holds that word.
module mem_rd_track
  import mem_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  trk_t push,
  output trk_t head
);

  trk_t [STAGES:1] vld_pipe;

  // Shift one slot per cycle; clr drops everything in flight
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= push;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign head = vld_pipe[STAGES];

endmodule

// File: rtl/mem_ctrl.sv
// Initiator for the 256x16 synchronous single-port memory: single writes,
// read bursts and whole-memory wipe, with registered pin drive and a
// response stream aligned to the memory's one-cycle read latency.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int addr_width = ADDR_W_DEF,
  parameter int data_width = DATA_W_DEF,
  parameter int len_width  = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  mem_ctrl_if.slave             bus,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_ce,
  output logic                  mem_rw,
  output logic [data_width-1:0] mem_din,
  output logic                  mem_clr_n,
  input  logic [data_width-1:0] mem_dout
);

  logic [2:0]            state;
  logic [len_width-1:0]  cnt;        // words still to issue after the current one
  logic                  req_ready;
  logic                  take_read;
  trk_t                  push;
  trk_t                  head;
  logic                  rsp_valid;
  logic                  rsp_last;
  logic [data_width-1:0] rsp_data;

  assign req_ready     = (state == ST_IDLE) && !clr;
  assign take_read     = req_ready && !bus.wipe && bus.req_valid && (bus.req_rw == RW_READ);
  assign bus.req_ready = req_ready;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_last  = rsp_last;
  assign bus.rsp_data  = rsp_data;

  // Mark a read slot whenever a read address is launched this edge
  always_comb begin
    push = '0;
    if (take_read) begin
      push.vld  = 1'b1;
      push.last = (bus.req_len == '0);
    end else if (state == ST_RD_ISSUE && cnt != '0) begin
      push.vld  = 1'b1;
      push.last = (cnt == len_width'(1));
    end
  end

  mem_rd_track #(.STAGES(2)) u_track (
    .clk  (clk),
    .clr  (clr),
    .push (push),
    .head (head)
  );

  // Command FSM and memory pin registers; wipe beats a pending request
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_ce    <= 1'b0;
      mem_rw    <= RW_READ;
      mem_din   <= '0;
      mem_clr_n <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.wipe) begin
            mem_clr_n <= 1'b0;
            mem_ce    <= 1'b0;
            state     <= ST_WIPE;
          end else if (bus.req_valid) begin
            mem_addr <= bus.req_addr;
            mem_ce   <= 1'b1;
            if (bus.req_rw == RW_READ) begin
              mem_rw <= RW_READ;
              cnt    <= bus.req_len;
              state  <= ST_RD_ISSUE;
            end else begin
              mem_rw  <= RW_WRITE;
              mem_din <= bus.req_wdata;
              state   <= ST_WR;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (cnt == '0) begin
            mem_ce <= 1'b0;
            state  <= ST_RD_DRAIN;
          end else begin
            mem_addr <= mem_addr + addr_width'(1);   // wraps at top of memory
            cnt      <= cnt - len_width'(1);
          end
        end
        ST_RD_DRAIN: state <= ST_IDLE;               // last word lands this edge
        ST_WR: begin
          mem_ce <= 1'b0;
          mem_rw <= RW_READ;
          state  <= ST_IDLE;
        end
        ST_WIPE: begin
          mem_clr_n <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture read data only in tracked slots; mem_dout floats otherwise
  always_ff @(posedge clk) begin
    if (clr) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= head.vld;
      rsp_last  <= head.vld & head.last;
      if (head.vld) rsp_data <= mem_dout;
    end
  end

endmodule
